// File: rtl/hhv2_core.sv
// ---------------------------------------------------------------------------
// hhv2_core - fully pipelined hyperbolic CORDIC in rotation mode.
//
// Computes cosh(z) and sinh(z) of a Q6.26 angle. The sequence of shift indices
// is i = 1..N_ITER, with i = 4 and i = 13 each executed twice. This gives
// N_ITER+2 iteration stages and a latency of N_ITER+2 cycles: 18 at the default
// N_ITER = 16. A new angle is accepted on every clock.
//
// Parameter
//   N_ITER  highest shift index executed (legal 13..24, default 16)
//
// Ports
//   clk   in   1   rising-edge clock
//   man   in   32  angle z, signed Q6.26, sampled every cycle
//   xvo   out  32  cosh(z), signed Q6.26, registered
//   yvo   out  32  sinh(z), signed Q6.26, registered
//   zvo   out  32  residual angle, signed Q6.26, registered
//   rst   in   1   synchronous active-high reset
//   expo  out  32  xvo + yvo = e^z, signed Q6.26, registered
//                  (present only when HHV2_EXP_OUT_EN is defined)
//
// Configuration macro: HHV2_EXP_OUT_EN adds the expo output and its adder.
// ---------------------------------------------------------------------------
module hhv2_core #(
    parameter int N_ITER = 16
) (
    input  logic        clk,
    input  logic [31:0] man,
    output logic [31:0] xvo,
    output logic [31:0] yvo,
    output logic [31:0] zvo,
    input  logic        rst
`ifdef HHV2_EXP_OUT_EN
    ,
    output logic [31:0] expo
`endif
);

    localparam int NS = N_ITER + 2;           // iteration stages (4 and 13 repeated)
    localparam int CW = $clog2(NS + 1);
    localparam logic [CW-1:0] FILL_MAX = CW'(NS);

    // round(2^26 / K) for the executed sequence. The exact value sits very close
    // to a half-LSB boundary and tips over once indices 17 and up are included.
    localparam logic signed [31:0] X_INIT = (N_ITER >= 17) ? 32'sd81033757 : 32'sd81033756;

    // Shift index used by iteration stage k (0-based): one extra step at i=4 and i=13.
    function automatic int shift_of(input int k);
        return k + 1 - ((k >= 4) ? 1 : 0) - ((k >= 14) ? 1 : 0);
    endfunction

    // atanh(2^-i) in Q6.26, rounded to nearest.
    function automatic logic signed [31:0] atanh_q26(input int i);
        case (i)
            1:       return 32'sd36863311;
            2:       return 32'sd17140464;
            3:       return 32'sd8432713;
            4:       return 32'sd4199778;
            5:       return 32'sd2097835;
            6:       return 32'sd1048661;
            7:       return 32'sd524299;
            8:       return 32'sd262145;
            9:       return 32'sd131072;
            10:      return 32'sd65536;
            11:      return 32'sd32768;
            12:      return 32'sd16384;
            13:      return 32'sd8192;
            14:      return 32'sd4096;
            15:      return 32'sd2048;
            16:      return 32'sd1024;
            17:      return 32'sd512;
            18:      return 32'sd256;
            19:      return 32'sd128;
            20:      return 32'sd64;
            21:      return 32'sd32;
            22:      return 32'sd16;
            23:      return 32'sd8;
            24:      return 32'sd4;
            default: return 32'sd0;
        endcase
    endfunction

    // x_reg[0]/y_reg[0]/z_reg[0] is the input register; x_reg[k] holds the
    // result of iteration k. The last iteration lands directly in xvo/yvo/zvo.
    logic signed [31:0] x_reg [0:NS-1];
    logic signed [31:0] y_reg [0:NS-1];
    logic signed [31:0] z_reg [0:NS-1];
    logic signed [31:0] x_nxt [1:NS];
    logic signed [31:0] y_nxt [1:NS];
    logic signed [31:0] z_nxt [1:NS];

    logic [CW-1:0] fill_reg;
    logic          out_en;

    // The pipeline itself is never gated; the fill counter only decides whether
    // the output registers take the final iteration or stay at zero. Zeros left
    // in the stages by reset do not produce zero results, hence the gating.
    assign out_en = (fill_reg == FILL_MAX);

    for (genvar gi = 1; gi <= NS; gi++) begin : g_iter
        localparam int SH = shift_of(gi - 1);
        localparam logic signed [31:0] ATANH = atanh_q26(SH);
        logic neg;

        assign neg = z_reg[gi-1][31];
        assign x_nxt[gi] = neg ? x_reg[gi-1] - (y_reg[gi-1] >>> SH)
                               : x_reg[gi-1] + (y_reg[gi-1] >>> SH);
        assign y_nxt[gi] = neg ? y_reg[gi-1] - (x_reg[gi-1] >>> SH)
                               : y_reg[gi-1] + (x_reg[gi-1] >>> SH);
        assign z_nxt[gi] = neg ? z_reg[gi-1] + ATANH
                               : z_reg[gi-1] - ATANH;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NS; k++) begin
                x_reg[k] <= '0;
                y_reg[k] <= '0;
                z_reg[k] <= '0;
            end
            fill_reg <= '0;
            xvo      <= '0;
            yvo      <= '0;
            zvo      <= '0;
        end else begin
            x_reg[0] <= X_INIT;
            y_reg[0] <= '0;
            z_reg[0] <= man;
            for (int k = 1; k < NS; k++) begin
                x_reg[k] <= x_nxt[k];
                y_reg[k] <= y_nxt[k];
                z_reg[k] <= z_nxt[k];
            end
            if (fill_reg != FILL_MAX) begin
                fill_reg <= fill_reg + 1'b1;
            end
            xvo <= out_en ? x_nxt[NS] : '0;
            yvo <= out_en ? y_nxt[NS] : '0;
            zvo <= out_en ? z_nxt[NS] : '0;
        end
    end

`ifdef HHV2_EXP_OUT_EN
    // cosh + sinh = e^z, taken from the same final-stage values so it lines up
    // with xvo/yvo.
    always_ff @(posedge clk) begin
        if (rst) begin
            expo <= '0;
        end else begin
            expo <= out_en ? (x_nxt[NS] + y_nxt[NS]) : '0;
        end
    end
`endif

endmodule

// File: tb/tb_hhv2_core.sv
// ---------------------------------------------------------------------------
// tb_hhv2_core - self-checking bench for hhv2_core.
//
// Every cycle the outputs are compared bit-exactly against a reference that
// applies the CORDIC rules on plain integers (constants derived here from
// $ln/$sqrt), including the zero-fill after reset. In-range angles are also
// checked against real cosh/sinh. A table of known angles and short
// hand-written sequences cover the latency, streaming and mid-stream reset
// cases.
// ---------------------------------------------------------------------------
module tb_hhv2_core;

    localparam int  N_ITER = 16;
    localparam int  LAT    = N_ITER + 2;
    localparam int  MAXE   = 4096;
    localparam real SC     = 67108864.0;
    localparam real TOL    = 1.0 / 16384.0;
    localparam int  RANGE  = 73819750;      // 1.1 in Q6.26

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] man;
    logic [31:0] xvo, yvo, zvo;
`ifdef HHV2_EXP_OUT_EN
    logic [31:0] expo;
`endif

    always #5 clk = ~clk;

    hhv2_core #(.N_ITER(N_ITER)) dut (
        .clk (clk),
        .man (man),
        .xvo (xvo),
        .yvo (yvo),
        .zvo (zvo),
        .rst (rst)
`ifdef HHV2_EXP_OUT_EN
        ,
        .expo(expo)
`endif
    );

    int tests = 0;
    int fails = 0;

    // reference constants
    int at_tab [1:32];
    int x0_mdl;
    int seq [$];

    // per-edge history
    logic [31:0] man_log [MAXE];
    logic [31:0] ox [MAXE];
    logic [31:0] oy [MAXE];
    logic [31:0] oz [MAXE];
    int t = 0;
    int last_rst = -1000;

    typedef struct {
        string       nm;
        logic [31:0] m;
        real         ec;
        real         es;
        real         ee;
    } vec_t;

    function automatic int rnd(input real v);
        return $rtoi(v + 0.5);
    endfunction

    function automatic real to_r(input logic [31:0] v);
        return $itor($signed(v)) / SC;
    endfunction

    function automatic real rabs(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    function automatic real rcosh(input real a);
        return ($exp(a) + $exp(-a)) / 2.0;
    endfunction

    function automatic real rsinh(input real a);
        return ($exp(a) - $exp(-a)) / 2.0;
    endfunction

    // Rotation-mode CORDIC applied straight from the iteration rules.
    function automatic void model(input logic [31:0] zin,
                                  output logic [31:0] xo,
                                  output logic [31:0] yo,
                                  output logic [31:0] zo);
        logic signed [31:0] x, y, z, xn, yn;
        x = x0_mdl;
        y = 0;
        z = zin;
        foreach (seq[k]) begin
            int i;
            i = seq[k];
            if (z >= 0) begin
                xn = x + (y >>> i);
                yn = y + (x >>> i);
                z  = z - at_tab[i];
            end else begin
                xn = x - (y >>> i);
                yn = y - (x >>> i);
                z  = z + at_tab[i];
            end
            x = xn;
            y = yn;
        end
        xo = x;
        yo = y;
        zo = z;
    endfunction

    task automatic chk32(input string nm, input int e, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s edge %0d: got %h, want %h", nm, e, act, exp);
        end
    endtask

    task automatic chk_tol(input string nm, input int e, input real act, input real exp, input real tol);
        tests++;
        if (rabs(act - exp) > tol) begin
            fails++;
            $display("[TB] FAIL %s edge %0d: got %f, want %f (tol %g)", nm, e, act, exp, tol);
        end
    endtask

    // Drive one sample, clock it, then compare everything the edge produced.
    task automatic step(input logic r, input logic [31:0] m);
        logic [31:0] ex, ey, ez;
        logic        valid;
        real         a;
        rst = r;
        man = m;
        @(posedge clk);
        t++;
        man_log[t] = m;
        if (r) last_rst = t;
        @(negedge clk);
        ox[t] = xvo;
        oy[t] = yvo;
        oz[t] = zvo;
        valid = !r && (t - last_rst >= LAT + 1);
        if (valid) begin
            model(man_log[t-LAT], ex, ey, ez);
        end else begin
            ex = '0;
            ey = '0;
            ez = '0;
        end
        chk32("xvo", t, xvo, ex);
        chk32("yvo", t, yvo, ey);
        chk32("zvo", t, zvo, ez);
`ifdef HHV2_EXP_OUT_EN
        chk32("expo", t, expo, ex + ey);
`endif
        if (valid) begin
            a = to_r(man_log[t-LAT]);
            $display("[TB] edge %0d man=%h -> x=%h y=%h z=%h", t, man_log[t-LAT], xvo, yvo, zvo);
            if ($signed(man_log[t-LAT]) <= RANGE && $signed(man_log[t-LAT]) >= -RANGE) begin
                chk_tol("cosh", t, to_r(xvo), rcosh(a), TOL);
                chk_tol("sinh", t, to_r(yvo), rsinh(a), TOL);
                chk_tol("resid", t, to_r(zvo), 0.0, TOL);
            end
        end
    endtask

    function automatic logic [31:0] rand_in();
        int v;
        if ($urandom_range(7) == 0) return $urandom;
        v = int'($urandom_range(2 * RANGE)) - RANGE;
        return v;
    endfunction

    initial begin
        vec_t        vecs [6];
        logic [31:0] s_m [4];
        real         s_c [4];
        real         s_s [4];
        real         kprod;
        int          r0;

        // reference constants from first principles
        kprod = 1.0;
        for (int i = 1; i <= N_ITER; i++) begin
            seq.push_back(i);
            if (i == 4 || i == 13) seq.push_back(i);
        end
        foreach (seq[k]) begin
            real p;
            p = 1.0;
            repeat (seq[k]) p = p / 2.0;
            kprod = kprod * $sqrt(1.0 - p * p);
        end
        x0_mdl = rnd(SC / kprod);
        for (int i = 1; i <= 32; i++) begin
            real p;
            p = 1.0;
            repeat (i) p = p / 2.0;
            at_tab[i] = rnd(SC * 0.5 * $ln((1.0 + p) / (1.0 - p)));
        end

        vecs[0] = '{"zero",    32'h00000000, 1.0,     0.0,      1.0};
        vecs[1] = '{"0.4577",  32'h01D4B2BE, 1.10659, 0.47386,  1.58045};
        vecs[2] = '{"-0.5",    32'hFE000000, 1.12763, -0.52110, 0.60653};
        vecs[3] = '{"1.1",     32'h04666666, 1.66852, 1.33565,  3.00417};
        vecs[4] = '{"0.25",    32'h01000000, 1.03141, 0.25261,  1.28403};
        vecs[5] = '{"1.0",     32'h04000000, 1.54308, 1.17520,  2.71828};

        // reset state
        rst = 1'b1;
        man = '0;
        repeat (3) step(1'b1, 32'h12345678);

        // table: reset, hold the angle through the fill, check against known values
        for (int v = 0; v < 6; v++) begin
            step(1'b1, vecs[v].m);
            repeat (LAT + 1) step(1'b0, vecs[v].m);
            chk_tol({"tab_cosh_", vecs[v].nm}, t, to_r(xvo), vecs[v].ec, TOL + 1.0e-5);
            chk_tol({"tab_sinh_", vecs[v].nm}, t, to_r(yvo), vecs[v].es, TOL + 1.0e-5);
            chk_tol({"tab_resid_", vecs[v].nm}, t, to_r(zvo), 0.0, TOL);
`ifdef HHV2_EXP_OUT_EN
            chk_tol({"tab_expo_", vecs[v].nm}, t, to_r(expo), vecs[v].ee, 2.0 * TOL + 1.0e-5);
`endif
        end

        // back-to-back stream right after reset
        s_m = '{32'h00000000, 32'h01000000, 32'hFF000000, 32'h04000000};
        s_c = '{1.0, 1.03141, 1.03141, 1.54308};
        s_s = '{0.0, 0.25261, -0.25261, 1.17520};
        step(1'b1, 32'h0);
        r0 = t;
        for (int j = 0; j < 4; j++) step(1'b0, s_m[j]);
        repeat (LAT + 2) step(1'b0, 32'h0);
        chk32("stream_pre_latency", r0 + LAT, ox[r0 + LAT], 32'h0);
        for (int j = 0; j < 4; j++) begin
            chk_tol("stream_cosh", r0 + 1 + j + LAT, to_r(ox[r0 + 1 + j + LAT]), s_c[j], TOL + 1.0e-5);
            chk_tol("stream_sinh", r0 + 1 + j + LAT, to_r(oy[r0 + 1 + j + LAT]), s_s[j], TOL + 1.0e-5);
        end

        // reset pulse at cycle 10 of a running stream
        step(1'b1, 32'h0);
        for (int c = 1; c < 10; c++) step(1'b0, rand_in());
        step(1'b1, rand_in());
        r0 = t;
        repeat (LAT + 10) step(1'b0, rand_in());
        for (int e = r0; e <= r0 + LAT; e++) begin
            chk32("fill_hold_x", e, ox[e], 32'h0);
            chk32("fill_hold_y", e, oy[e], 32'h0);
        end

        // random stream against the reference
        repeat (300) step(1'b0, rand_in());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hhv2_core.md
HHV2_CORE -- requirements
Module: hhv2

Interface
REQ-001 Parameter N_ITER, default 16, meaning the highest shift index i executed; legal range 13..24.
REQ-002 clk  input  1  rising-edge clock; the block uses only this one clock.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 man  input  32  angle z, signed two's complement Q6.26 (26 fractional bits).
REQ-005 xvo  output  32  cosh(z), signed Q6.26, registered.
REQ-006 yvo  output  32  sinh(z), signed Q6.26, registered.
REQ-007 zvo  output  32  residual angle, signed Q6.26, registered.
REQ-008 Positional port order SHALL be clk, man, xvo, yvo, zvo, then rst; the block SHALL accept no other ports except the one in REQ-023.

Function
REQ-009 The block SHALL be a fully pipelined hyperbolic CORDIC in rotation mode.
REQ-010 Iteration sequence: i = 1..N_ITER, with i=4 and i=13 each executed twice.
REQ-011 With N_ITER=16 there are 18 stages.
REQ-012 Stage 0 SHALL register x = round(2^26/K), y = 0 and z = man.
REQ-013 K is the product of sqrt(1 - 2^-2i) over all executed iterations (including repeats).
REQ-014 Each stage update: d = +1 if z >= 0, else -1; x' = x + d*(y >>> i); y' = y + d*(x >>> i); z' = z - d*atanh(2^-i).
REQ-015 Shifts SHALL be arithmetic, and all adds SHALL be 32-bit wrapping two's complement.
REQ-016 atanh(2^-i) constants SHALL be Q6.26, rounded to nearest, held in a hardcoded table indexed by stage.
REQ-017 Latency: a man value present at rising edge n SHALL appear on xvo/yvo/zvo after rising edge n + (number of stages); this is 18 cycles at default.
REQ-018 Throughput: one new angle per clock; man is sampled every cycle and there is no handshake.
REQ-019 Accuracy: for |man| <= 1.1 (convergence range), |xvo - cosh| and |yvo - sinh| SHALL be <= 2^-14, and |zvo| SHALL be <= 2^-14.
REQ-020 Outside the convergence range the outputs are unspecified but SHALL be deterministic, with no X propagation.

Reset
REQ-021 While rst=1 at a rising edge, every pipeline register and xvo, yvo, zvo SHALL clear to 0.
REQ-022 An internal fill counter SHALL hold all three outputs at 0 until the first man sampled after reset has reached the output; outputs then update every cycle. Reset asserted mid-stream SHALL discard all in-flight data and restart the fill.

Configuration
REQ-023 Macro HHV2_EXP_OUT_EN: when defined, the block SHALL add output expo (32, Q6.26, registered) equal to xvo + yvo, i.e. e^z. expo SHALL have the same latency as the other outputs and SHALL reset to 0.
REQ-024 When HHV2_EXP_OUT_EN is undefined, port expo and its adder SHALL NOT exist.

Verification
REQ-025 Reset, then man=0x00000000 -> after 18 cycles xvo≈1.0 (0x04000000 ±2^-14 scaled), yvo≈0, zvo≈0; all outputs 0 before that.
REQ-026 man=0x01D4B2BE (0.457720) held constant -> xvo≈1.10659, yvo≈0.47386, |zvo|<=2^-14; with the macro defined, expo≈1.58045.
REQ-027 man=-0.5 (0xFE000000) -> xvo≈1.12763, yvo≈-0.52110 within tolerance.
REQ-028 Back-to-back stream 0, 0.25, -0.25, 1.0, one per cycle -> outputs appear in order on consecutive cycles starting at latency 18; values are cosh/sinh of 0/0.25/-0.25/1.0 (1.0/0, 1.03141/0.25261, 1.03141/-0.25261, 1.54308/1.17520).
REQ-029 Assert rst for 1 cycle at cycle 10 of a running stream -> outputs 0 at the next edge and held 0 for the full fill time; correct results resume thereafter.
REQ-030 man=1.1 (upper convergence bound) -> xvo≈1.66852, yvo≈1.33565 within 2^-14.
